// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchroniser, centre-sampling FSM, registered byte/strobes.
// Define UART_RX_PARITY_EN to add an even-parity bit after the data bits.
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 1,
  parameter int unsigned m            = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_Rx_serial,
  input  logic         i_enable,
  output logic         o_Rx_DV,
  output logic [m-1:0] o_Rx_b,
  output logic         o_Rx_active,
  output logic         o_frame_err,
  output logic         o_parity_err
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam int unsigned IDX_W = (m > 1) ? $clog2(m) : 1;

  localparam logic [CNT_W-1:0] HALF     = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] LAST     = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(m - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_DATA    = 3'd2,
    S_PARITY  = 3'd3,
    S_STOP    = 3'd4,
    S_CLEANUP = 3'd5
  } state_t;

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [IDX_W-1:0] idx, idx_d;
  logic [m-1:0]     shreg, shreg_d;
  logic [m-1:0]     rx_b_d;
  logic             dv_d, fe_d, pe_d, active_d;
  logic             rx_meta, rx_s;
  logic             parity_bad;

`ifdef UART_RX_PARITY_EN
  logic par, par_d;
  assign parity_bad = (^shreg) ^ par;
`else
  assign parity_bad = 1'b0;
`endif

  // Line synchroniser; idles high so reset never looks like a start bit
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= i_Rx_serial;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= S_IDLE;
      cnt          <= '0;
      idx          <= '0;
      shreg        <= '0;
      o_Rx_b       <= '0;
      o_Rx_DV      <= 1'b0;
      o_Rx_active  <= 1'b0;
      o_frame_err  <= 1'b0;
      o_parity_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par          <= 1'b0;
`endif
    end else begin
      state        <= state_d;
      cnt          <= cnt_d;
      idx          <= idx_d;
      shreg        <= shreg_d;
      o_Rx_b       <= rx_b_d;
      o_Rx_DV      <= dv_d;
      o_Rx_active  <= active_d;
      o_frame_err  <= fe_d;
      o_parity_err <= pe_d;
`ifdef UART_RX_PARITY_EN
      par          <= par_d;
`endif
    end
  end

  // Next-state and output decode; strobes default low so they last one cycle
  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    idx_d    = idx;
    shreg_d  = shreg;
    rx_b_d   = o_Rx_b;
    dv_d     = 1'b0;
    fe_d     = 1'b0;
    pe_d     = 1'b0;
    active_d = o_Rx_active;
`ifdef UART_RX_PARITY_EN
    par_d    = par;
`endif
    case (state)
      S_IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (i_enable && !rx_s) begin
          state_d  = S_START;
          active_d = 1'b1;
        end
      end
      S_START: begin
        if (cnt == HALF) begin
          cnt_d = '0;
          if (!rx_s) begin
            state_d = S_DATA;
          end else begin
            state_d  = S_IDLE;
            active_d = 1'b0;
          end
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (cnt == LAST) begin
          cnt_d        = '0;
          shreg_d[idx] = rx_s;
          if (idx == IDX_LAST) begin
            idx_d = '0;
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            idx_d = idx + IDX_W'(1);
          end
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (cnt == LAST) begin
          cnt_d   = '0;
          par_d   = rx_s;
          state_d = S_STOP;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
`endif
      S_STOP: begin
        if (cnt == LAST) begin
          cnt_d   = '0;
          state_d = S_CLEANUP;
          if (!rx_s) begin
            fe_d = 1'b1;
          end else if (parity_bad) begin
            pe_d = 1'b1;
          end else begin
            dv_d   = 1'b1;
            rx_b_d = shreg;
          end
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      S_CLEANUP: begin
        state_d  = S_IDLE;
        active_d = 1'b0;
      end
      default: begin
        state_d  = S_IDLE;
        active_d = 1'b0;
        cnt_d    = '0;
        idx_d    = '0;
      end
    endcase
  end

endmodule
